// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types, error-bit positions and the channel priority search for the ADC scan scheduler.
package adc_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 8;
    localparam int MAX_CH     = 8;

    localparam int ERR_TICK = 0;
    localparam int ERR_DROP = 1;
    localparam int ERR_TMO  = 2;

    typedef enum logic [1:0] {IDLE, REQ, NEXT, DONE} state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } ch_sel_t;

    // Lowest set bit of mask at or above position from.
    function automatic ch_sel_t next_set_ch(input logic [MAX_CH-1:0] mask, input int from);
        ch_sel_t sel;
        sel = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                sel.found = 1'b1;
                sel.idx   = 3'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Conversion handshake towards the ADC engine and frame handshake towards the beamformer.
interface adc_scan_scheduler_if
    import adc_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     conv_req;
    logic [CH_W-1:0]          conv_chan;
    logic                     conv_ack;
    logic [DATA_W-1:0]        conv_data;
    logic                     frame_valid;
    logic                     frame_ready;
    logic [NUM_CH*DATA_W-1:0] frame_data;
    logic [7:0]               frame_seq;

    modport master (
        output conv_req, conv_chan, frame_valid, frame_data, frame_seq,
        input  conv_ack, conv_data, frame_ready
    );

    modport slave (
        input  conv_req, conv_chan, frame_valid, frame_data, frame_seq,
        output conv_ack, conv_data, frame_ready
    );

endinterface

// File: rtl/adc_scan_scheduler_tick.sv
// Sample-rate tick: one pulse every period+1 cycles while enabled.
module sample_tick_gen #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] r_cnt;
    logic                w_hit;

    assign w_hit = (r_cnt == period);
    assign tick  = enable && w_hit;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (!enable || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Scans the enabled ADC channels once per sample tick and publishes them as one atomic frame.
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [NUM_CH-1:0]   chan_mask,
    adc_scan_scheduler_if.master bus,
    output logic [2:0]          err_flags,
    input  logic                err_clr,
    output logic                busy
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t                   r_state, w_state_nxt;
    logic [NUM_CH-1:0]        r_scan_mask;
    logic [CH_W-1:0]          r_ch;
    logic [WAIT_W-1:0]        r_wait;
    logic [NUM_CH*DATA_W-1:0] r_buf, r_frame_data;
    logic                     r_frame_valid;
    logic [7:0]               r_frame_seq, r_seq_cnt;
    logic [2:0]               r_err;

    logic    w_tick, w_conv_req;
    logic    w_start, w_got, w_tmo, w_publish, w_drop;
    logic [2:0] w_err_set;
    ch_sel_t w_first, w_next;

    sample_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
        .clk     (clk),
        .n_reset (n_reset),
        .enable  (enable),
        .period  (period),
        .tick    (w_tick)
    );

    assign w_first = next_set_ch(MAX_CH'(chan_mask), 0);
    assign w_next  = next_set_ch(MAX_CH'(r_scan_mask), int'(r_ch) + 1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_conv_req  = 1'b0;
        w_start     = 1'b0;
        w_got       = 1'b0;
        w_tmo       = 1'b0;
        w_publish   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick && w_first.found) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_conv_req = 1'b1;
                if (bus.conv_ack) begin
                    w_got       = 1'b1;
                    w_state_nxt = NEXT;
                end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = NEXT;
                end
            end
            NEXT: w_state_nxt = w_next.found ? REQ : DONE;
            DONE: begin
                w_state_nxt = IDLE;
                if (!r_frame_valid || bus.frame_ready) w_publish = 1'b1;
                else                                   w_drop    = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_err_set           = '0;
        w_err_set[ERR_TICK] = w_tick && (r_state != IDLE);
        w_err_set[ERR_DROP] = w_drop;
        w_err_set[ERR_TMO]  = w_tmo;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_scan_mask   <= '0;
            r_ch          <= '0;
            r_wait        <= '0;
            r_buf         <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_frame_seq   <= '0;
            r_seq_cnt     <= '0;
            r_err         <= '0;
        end else begin
            if (w_start) begin
                r_scan_mask <= chan_mask;
                r_ch        <= CH_W'(w_first.idx);
                r_buf       <= '0;
            end
            if (r_state == NEXT && w_next.found) r_ch <= CH_W'(w_next.idx);
            r_wait <= (r_state == REQ && !w_got && !w_tmo) ? r_wait + 1'b1 : '0;
            // A timed-out channel reads 0 so the frame never carries a stale sample.
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_ch == CH_W'(i)) begin
                    if (w_got)      r_buf[i*DATA_W +: DATA_W] <= bus.conv_data;
                    else if (w_tmo) r_buf[i*DATA_W +: DATA_W] <= '0;
                end
            end
            if (w_publish) begin
                r_frame_data  <= r_buf;
                r_frame_valid <= 1'b1;
                r_frame_seq   <= r_seq_cnt;
                r_seq_cnt     <= r_seq_cnt + 1'b1;
            end else if (r_frame_valid && bus.frame_ready) begin
                r_frame_valid <= 1'b0;
            end
            r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
        end
    end

    assign bus.conv_req    = w_conv_req;
    assign bus.conv_chan   = r_ch;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_data  = r_frame_data;
    assign bus.frame_seq   = r_frame_seq;
    assign err_flags       = r_err;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural ADC engine and frame consumer.
module tb_adc_scan_scheduler;
    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 8;
    localparam int PERIOD_W = 16;
    localparam int TIMEOUT  = 255;

    logic                clk = 1'b0;
    logic                n_reset = 1'b0;
    logic                enable = 1'b0;
    logic                err_clr = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic [NUM_CH-1:0]   chan_mask = '0;
    logic [2:0]          err_flags;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int ack_lat = 3;
    int nak_ch = -1;
    int req_cnt = 0;
    int chan_q[$];
    int dur_q[$];

    adc_scan_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    adc_scan_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .enable    (enable),
        .period    (period),
        .chan_mask (chan_mask),
        .bus       (bus.master),
        .err_flags (err_flags),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame(input string tag, input int max);
        int k = 0;
        while (!bus.frame_valid && k < max) begin
            step(1);
            k++;
        end
        check_eq({tag, "_seen"}, bus.frame_valid, 1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (busy && k < max) begin
            step(1);
            k++;
        end
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    function automatic logic [63:0] pack_q(input int q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = (v << 4) | 64'(q[i]);
        return v;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // ADC engine model: acks ack_lat samples after req rises, data = ch*16+5, never acks nak_ch.
    initial begin
        int   age = 0;
        int   dur = 0;
        bit   acked = 0;
        logic prev_req = 1'b0;
        bus.conv_ack  = 1'b0;
        bus.conv_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.conv_ack = 1'b0;
            if (bus.conv_req) begin
                if (!prev_req) begin
                    chan_q.push_back(int'(bus.conv_chan));
                    req_cnt++;
                    age   = 0;
                    dur   = 0;
                    acked = 0;
                end
                age++;
                dur++;
                if (!acked && age == ack_lat && int'(bus.conv_chan) != nak_ch) begin
                    bus.conv_ack  = 1'b1;
                    bus.conv_data = DATA_W'(int'(bus.conv_chan) * 16 + 5);
                    acked = 1;
                end
            end else if (prev_req) begin
                dur_q.push_back(dur);
            end
            prev_req = bus.conv_req;
        end
    end

    initial begin
        int t0;
        bus.frame_ready = 1'b1;
        step(3);
        check_eq("rst_req",   bus.conv_req, 0);
        check_eq("rst_valid", bus.frame_valid, 0);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_err",   err_flags, 0);
        check_eq("rst_seq",   bus.frame_seq, 0);
        check_eq("rst_data",  bus.frame_data, 0);
        n_reset = 1'b1;

        // 1: full mask, period 99
        period    = 16'd99;
        chan_mask = 4'b1111;
        enable    = 1'b1;
        wait_frame("t1_f0", 300);
        check_eq("t1_f0_data", bus.frame_data, 64'h35251505);
        check_eq("t1_f0_seq",  bus.frame_seq, 0);
        t0 = cyc;
        step(1);
        check_eq("t1_accept", bus.frame_valid, 0);
        wait_frame("t1_f1", 150);
        check_eq("t1_f1_seq", bus.frame_seq, 1);
        check_eq("t1_f1_gap", cyc - t0, 100);
        check_eq("t1_f1_data", bus.frame_data, 64'h35251505);
        step(1);
        wait_frame("t1_f2", 150);
        check_eq("t1_f2_seq", bus.frame_seq, 2);
        check_eq("t1_err", err_flags, 0);
        step(1);

        // 2: sparse mask
        chan_mask = 4'b0101;
        chan_q.delete();
        wait_frame("t2", 150);
        check_eq("t2_data", bus.frame_data, 64'h00250005);
        check_eq("t2_seq", bus.frame_seq, 3);
        check_eq("t2_nreq", chan_q.size(), 2);
        check_eq("t2_chans", pack_q(chan_q), 64'h02);
        step(1);

        // 3: back-pressure holds the first frame and drops the next
        chan_mask       = 4'b1111;
        bus.frame_ready = 1'b0;
        wait_frame("t3", 150);
        check_eq("t3_seq", bus.frame_seq, 4);
        step(150);
        check_eq("t3_held_valid", bus.frame_valid, 1);
        check_eq("t3_held_seq", bus.frame_seq, 4);
        check_eq("t3_held_data", bus.frame_data, 64'h35251505);
        check_eq("t3_err_drop", err_flags, 3'b010);
        pulse_clr();
        check_eq("t3_err_clr", err_flags, 0);
        bus.frame_ready = 1'b1;
        step(1);
        check_eq("t3_release", bus.frame_valid, 0);
        wait_frame("t3_next", 150);
        check_eq("t3_next_seq", bus.frame_seq, 5);
        step(1);

        // 4: ticks faster than a scan
        enable = 1'b0;
        wait_idle("t4", 400);
        period  = 16'd3;
        ack_lat = 10;
        pulse_clr();
        req_cnt = 0;
        enable  = 1'b1;
        wait_frame("t4_f0", 200);
        check_eq("t4_err_tick", err_flags, 3'b001);
        check_eq("t4_data", bus.frame_data, 64'h35251505);
        check_eq("t4_seq0", bus.frame_seq, 6);
        check_eq("t4_nreq0", req_cnt, 4);
        req_cnt = 0;
        step(1);
        wait_frame("t4_f1", 200);
        check_eq("t4_seq1", bus.frame_seq, 7);
        check_eq("t4_nreq1", req_cnt, 4);
        step(1);

        // 5: channel 1 never acknowledged
        enable = 1'b0;
        wait_idle("t5", 200);
        period  = 16'd999;
        ack_lat = 3;
        nak_ch  = 1;
        pulse_clr();
        chan_q.delete();
        dur_q.delete();
        enable = 1'b1;
        wait_frame("t5", 1500);
        check_eq("t5_data", bus.frame_data, 64'h35250005);
        check_eq("t5_err_tmo", err_flags, 3'b100);
        check_eq("t5_seq", bus.frame_seq, 8);
        check_eq("t5_chans", pack_q(chan_q), 64'h0123);
        check_eq("t5_dur_ch1", qget(dur_q, 1), TIMEOUT);
        check_eq("t5_dur_ch0", qget(dur_q, 0), 3);
        step(1);

        // 6: asynchronous reset during a request
        nak_ch = -1;
        enable = 1'b0;
        step(1);
        period          = 16'd99;
        enable          = 1'b1;
        bus.frame_ready = 1'b0;
        wait_frame("t6_hold", 300);
        check_eq("t6_hold_seq", bus.frame_seq, 9);
        begin
            int k = 0;
            while (!bus.conv_req && k < 200) begin
                step(1);
                k++;
            end
        end
        check_eq("t6_in_req", bus.conv_req, 1);
        n_reset = 1'b0;
        #1;
        check_eq("t6_req_drop", bus.conv_req, 0);
        check_eq("t6_valid_drop", bus.frame_valid, 0);
        check_eq("t6_busy_drop", busy, 0);
        check_eq("t6_seq_rst", bus.frame_seq, 0);
        step(2);
        n_reset         = 1'b1;
        chan_mask       = 4'b1110;
        bus.frame_ready = 1'b1;
        chan_q.delete();
        wait_frame("t6_after", 300);
        check_eq("t6_after_seq", bus.frame_seq, 0);
        check_eq("t6_after_data", bus.frame_data, 64'h35251500);
        check_eq("t6_after_chans", pack_q(chan_q), 64'h123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
